// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, register-bank write port,
// per-register pending-write scoreboard and same-cycle bypass for decode.
module wb_stage #(
   parameter int DEPTH_BITS = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        mem_valid,
   input  logic        mem_reg_write,
   input  logic        mem_mem_to_reg,
   input  logic [4:0]  mem_write_id,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_read_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_id,
   input  logic [4:0]  rs_id,
   input  logic [4:0]  rt_id,
   output logic        wb_reg_write,
   output logic [4:0]  wb_write_id,
   output logic [31:0] wb_write_value,
   output logic        rs_busy,
   output logic        rt_busy,
   output logic        rs_fwd_valid,
   output logic [31:0] rs_fwd_value,
   output logic        rt_fwd_valid,
   output logic [31:0] rt_fwd_value,
   output logic        sb_error
);

   localparam logic [DEPTH_BITS-1:0] C_CNT_MAX  = {DEPTH_BITS{1'b1}};
   localparam logic [DEPTH_BITS-1:0] C_CNT_ZERO = {DEPTH_BITS{1'b0}};
   localparam logic [DEPTH_BITS-1:0] C_CNT_ONE  = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

   // MEM/WB pipeline register
   logic        r_valid;
   logic        r_reg_write;
   logic [4:0]  r_id;
   logic [31:0] r_value;
   // high only in the first cycle an entry is presented, so a held entry retires once
   logic        r_fresh;

   // scoreboard state; entry 0 is never written and stays at zero
   logic [DEPTH_BITS-1:0] r_count [32];
   logic                  r_sb_error;

   logic        w_write_en;
   logic        w_retire;
   logic [31:0] w_inc_vec;
   logic [31:0] w_dec_vec;
   logic [DEPTH_BITS-1:0] w_rs_cnt;
   logic [DEPTH_BITS-1:0] w_rt_cnt;
   logic        w_rs_hit;
   logic        w_rt_hit;

   // Capture, hold or invalidate the MEM/WB entry
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_id        <= 5'd0;
         r_value     <= 32'd0;
         r_fresh     <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_fresh <= 1'b0;
      end else if (stall) begin
         r_fresh <= 1'b0;
      end else begin
         r_valid     <= mem_valid;
         r_reg_write <= mem_reg_write;
         r_id        <= mem_write_id;
         r_value     <= mem_mem_to_reg ? mem_read_data : mem_alu_result;
         r_fresh     <= 1'b1;
      end
   end

   // Write port and retire qualification, all from latched state
   always_comb begin
      w_write_en = r_valid & r_reg_write & (r_id != 5'd0);
      w_retire   = w_write_en & r_fresh;
   end

   // One-hot increment/decrement requests for the scoreboard
   always_comb begin
      w_inc_vec = 32'd0;
      w_dec_vec = 32'd0;
      if (issue_valid && (issue_id != 5'd0)) begin
         w_inc_vec[issue_id] = 1'b1;
      end else begin
         w_inc_vec = 32'd0;
      end
      if (w_retire) begin
         w_dec_vec[r_id] = 1'b1;
      end else begin
         w_dec_vec = 32'd0;
      end
   end

   // Pending-write counters with saturation and sticky error flag
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) begin
            r_count[i] <= C_CNT_ZERO;
         end
         r_sb_error <= 1'b0;
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (w_inc_vec[i] && !w_dec_vec[i]) begin
               if (r_count[i] == C_CNT_MAX) begin
                  r_sb_error <= 1'b1;
               end else begin
                  r_count[i] <= r_count[i] + C_CNT_ONE;
               end
            end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
               if (r_count[i] == C_CNT_ZERO) begin
                  r_sb_error <= 1'b1;
               end else begin
                  r_count[i] <= r_count[i] - C_CNT_ONE;
               end
            end else begin
               r_count[i] <= r_count[i];
            end
         end
      end
   end

   // Decode-side busy and bypass for the rs/rt queries
   always_comb begin
      w_rs_cnt = r_count[rs_id];
      w_rt_cnt = r_count[rt_id];
      w_rs_hit = w_retire && (r_id == rs_id) && (rs_id != 5'd0);
      w_rt_hit = w_retire && (r_id == rt_id) && (rt_id != 5'd0);
      rs_busy  = (rs_id != 5'd0) &&
                 ((w_rs_cnt > C_CNT_ONE) || ((w_rs_cnt == C_CNT_ONE) && !w_rs_hit));
      rt_busy  = (rt_id != 5'd0) &&
                 ((w_rt_cnt > C_CNT_ONE) || ((w_rt_cnt == C_CNT_ONE) && !w_rt_hit));
      rs_fwd_valid = w_rs_hit;
      rt_fwd_valid = w_rt_hit;
      if (w_rs_hit) begin
         rs_fwd_value = r_value;
      end else begin
         rs_fwd_value = 32'd0;
      end
      if (w_rt_hit) begin
         rt_fwd_value = r_value;
      end else begin
         rt_fwd_value = 32'd0;
      end
   end

   assign wb_reg_write   = w_write_en;
   assign wb_write_id    = r_id;
   assign wb_write_value = r_value;
   assign sb_error       = r_sb_error;

endmodule
